// File: rtl/muldiv_ctrl_if.sv
// Issue/result bundle between the pipeline and the iterative multiply/divide sequencer.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     rs_val;
  logic [WIDTH-1:0]     rt_val;
  logic                 abort;
  logic                 mf_req;
  logic                 busy;
  logic                 hilo_we;
  logic [2*WIDTH-1:0]   hilo_wdata;
  logic                 stall;

  modport master (
    output start, op, rs_val, rt_val, abort, mf_req,
    input  busy, hilo_we, hilo_wdata, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, abort, mf_req,
    output busy, hilo_we, hilo_wdata, stall
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write port.
// Signed ops run on magnitudes; the sign is restored when the result is registered.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one shift-add / shift-subtract step per cycle, WIDTH cycles
// DONE   | hilo_we asserted for one cycle with fixed-up result
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] wdata;

  logic               sign_rs, sign_rt, op_div;
  logic [WIDTH-1:0]   mag_rs, mag_rt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod, fix;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    op_div  = bus.op[1];
    sign_rs = bus.op[0] & bus.rs_val[WIDTH-1];
    sign_rt = bus.op[0] & bus.rt_val[WIDTH-1];
    mag_rs  = sign_rs ? -bus.rs_val : bus.rs_val;
    mag_rt  = sign_rt ? -bus.rt_val : bus.rt_val;
  end

  // acc_hi holds partial product high half / partial remainder; acc_lo shifts out
  // multiplier bits (multiply) or dividend bits while collecting quotient bits (divide).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    if (is_div) begin
      nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    quot = neg_res ? -nxt_lo : nxt_lo;
    rem  = neg_rem ? -nxt_hi : nxt_hi;
    fix  = is_div ? {rem, quot} : (neg_res ? -prod : prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mag_b   <= '0;
      wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div  <= op_div;
            neg_res <= sign_rs ^ sign_rt;
            neg_rem <= sign_rs;
            acc_hi  <= '0;
            acc_lo  <= op_div ? mag_rs : mag_rt;
            mag_b   <= op_div ? mag_rt : mag_rs;
            cnt     <= CW'(WIDTH);
            if (op_div && (bus.rt_val == '0)) begin
              wdata <= {bus.rs_val, {WIDTH{1'b1}}};
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              wdata <= fix;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state so reset drops them without waiting for a clock.
  assign bus.busy       = (state != S_IDLE);
  assign bus.hilo_we    = (state == S_DONE);
  assign bus.hilo_wdata = wdata;
  assign bus.stall      = bus.mf_req & bus.busy;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: results, latency, busy/stall windows, abort and reset.
module tb_muldiv_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [63:0] last_wdata;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();
  muldiv_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // abort_at / restart_at: cycle index after the start edge during which the pulse is held.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat,
                       input bit mf, input int restart_at, input int abort_at,
                       input bit abort_start);
    int we_n, busy_n, stall_n, lat_seen;
    logic [63:0] data_seen;
    bit aborted;
    we_n = 0; busy_n = 0; stall_n = 0; lat_seen = 0; data_seen = '0;
    aborted = (abort_at > 0) && (abort_at < lat);
    @(negedge clk);
    bus.op = o; bus.rs_val = a; bus.rt_val = b;
    bus.start = 1'b1; bus.mf_req = mf; bus.abort = abort_start;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.stall) stall_n++;
      if (bus.hilo_we) begin
        we_n++;
        if (we_n == 1) begin
          lat_seen  = i;
          data_seen = bus.hilo_wdata;
        end
      end
      bus.start = (i == restart_at);
      bus.abort = (i == abort_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.mf_req = 1'b0;
    if (aborted) begin
      chk({tag, " we_count"}, 64'(we_n), 64'd0);
      chk({tag, " busy_cycles"}, 64'(busy_n), 64'(abort_at));
      chk({tag, " wdata_held"}, bus.hilo_wdata, last_wdata);
      chk({tag, " stall_cycles"}, 64'(stall_n), mf ? 64'(abort_at) : 64'd0);
    end else begin
      chk({tag, " we_count"}, 64'(we_n), 64'd1);
      chk({tag, " latency"}, 64'(lat_seen), 64'(lat));
      chk({tag, " data"}, data_seen, exp);
      chk({tag, " busy_cycles"}, 64'(busy_n), 64'(lat));
      chk({tag, " stall_cycles"}, 64'(stall_n), mf ? 64'(lat) : 64'd0);
      last_wdata = exp;
    end
    chk({tag, " idle_after"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int we_n;
    n_vec = 0; n_err = 0; last_wdata = '0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.abort = 1'b0; bus.mf_req = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {63'd0, bus.busy}, 64'd0);
    chk("rst hilo_we", {63'd0, bus.hilo_we}, 64'd0);
    chk("rst stall", {63'd0, bus.stall}, 64'd0);
    chk("rst wdata", bus.hilo_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mf_req = 1'b0;

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0, 0, 0, 0);
    do_op("mult_neg",  2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0, 0, 0, 0);
    do_op("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 0, 0, 0, 0);
    do_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 0, 0, 1);
    do_op("divu_stall",2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 33, 1, 5, 0, 0);
    do_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0, 0, 33, 0);
    do_op("divu_zero", 2'b10, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 1, 1, 0, 0, 0);
    do_op("abort_run", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 33, 0, 0, 10, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.op = 2'b00; bus.rs_val = 32'hDEAD_BEEF; bus.rt_val = 32'h0000_0011; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst busy", {63'd0, bus.busy}, 64'd0);
    chk("async_rst hilo_we", {63'd0, bus.hilo_we}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    we_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.hilo_we) we_n++;
    end
    chk("async_rst no_write", 64'(we_n), 64'd0);
    chk("async_rst wdata", bus.hilo_wdata, 64'd0);
    last_wdata = '0;

    do_op("multu_after_rst", 2'b00, 32'd3, 32'd5, 64'd15, 33, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that computes MULT/MULTU/DIV/DIVU results over multiple cycles. It drives the write port of the HI/LO register pair: one 64-bit write enable plus data, HI = upper half, LO = lower half. It also raises a pipeline stall when an MFHI/MFLO read arrives while an operation is still in flight.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
rs_val  input  WIDTH  multiplicand / dividend
rt_val  input  WIDTH  multiplier / divisor
abort  input  1  cancel the in-flight operation (exception/flush); no write occurs
mf_req  input  1  decode stage holds MFHI or MFLO this cycle
busy  output  1  operation in progress, including the DONE cycle
hilo_we  output  1  one-cycle write strobe to HI/LO
hilo_wdata  output  2*WIDTH  {HI, LO} write data
stall  output  1  pipeline stall request

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, hilo_we=0, hilo_wdata=0, stall=0; iteration counter, accumulators and sign flags cleared.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge latches op, the operand magnitudes and the sign flags, loads counter=WIDTH, and moves to RUN.
  - Exception: DIVU/DIV with rt_val=0 goes straight to DONE.
  - start=0: stay in IDLE.
- Operand preparation:
  - Unsigned ops (MULTU, DIVU): operands are used as-is.
  - Signed ops (MULT, DIV): magnitudes are formed by two's-complement negation of negative operands. Magnitudes are held as unsigned WIDTH-bit values, so 0x80000000 becomes 2^31 exactly.
  - neg_res = sign(rs) XOR sign(rt); neg_rem = sign(rs).
- RUN, one iteration per cycle, counter decrements each cycle:
  - Multiply: radix-2 shift-add.
  - Divide: restoring shift-subtract.
  - When counter reaches 1, the next edge moves to DONE. Exactly WIDTH cycles are spent in RUN.
- Result fix-up, registered on entry to DONE:
  - MULT: 2*WIDTH-bit product, negated if neg_res.
  - DIV: quotient negated if neg_res; remainder negated if neg_rem.
  - Mult: HI=product[2W-1:W], LO=product[W-1:0].
  - Div: HI=remainder, LO=quotient.
  - Divide by zero: HI=rs_val (raw bits), LO=all ones. No iteration.
  - Signed overflow -2^31 / -1: LO=0x80000000, HI=0. This is a natural result of the magnitude method; no special case is needed.
- DONE, exactly one cycle: hilo_we=1 and hilo_wdata is valid, then IDLE on the next edge. HI/LO capture the data at the end of the DONE cycle.
- busy is 1 in RUN and DONE, 0 in IDLE. It is registered, so busy rises in the cycle after the start edge.
- Latency:
  - Normal ops: start sampled at edge E; RUN occupies cycles E+1..E+WIDTH; DONE (hilo_we) is cycle E+WIDTH+1.
  - Divide by zero: DONE is cycle E+1.
- start while busy: ignored, with no queuing. The issuer must gate start with busy.
- stall = mf_req AND busy; combinational from the registered busy.
  - MFHI/MFLO in the DONE cycle still stalls, because HI/LO are updated only at the end of that cycle.
  - stall=0 in IDLE.
- abort:
  - In RUN: next edge returns to IDLE. hilo_we never asserts and HI/LO are untouched.
  - In DONE: abort has no effect; the write commits.
  - In IDLE: abort is ignored, and start is still accepted in the same cycle.
- Reset mid-operation returns to IDLE immediately. No write strobe is produced, and a partial result must never appear on hilo_we.
- hilo_wdata holds its last value outside DONE. Only hilo_we qualifies it.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles; hilo_we single pulse at E+33 with {HI,LO}=0xFFFFFFFE_00000001.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> {HI,LO}=0xFFFFFFFF_FFFFFFFA. Then MULT rs=rt=0x80000000 -> 0x40000000_00000000.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIVU rs=100, rt=7 -> LO=14, HI=2. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x1234, rt=0 -> DONE at E+1 with HI=0x00001234, LO=0xFFFFFFFF; busy high for exactly 1 cycle.
- Start MULTU; pulse abort in RUN cycle 10 -> idle next cycle, hilo_we never asserts. Separately, assert rst=0 asynchronously mid-RUN -> busy and hilo_we drop immediately, with no write after release.
- Hold mf_req=1 across a DIVU -> stall high from E+1 through E+33 inclusive, low at E+34. A second start pulsed at E+5 is ignored, with exactly one hilo_we.
